// File: rtl/mac_sequencer_if.sv
// Operand-buffer read ports plus the command and result signals of the dot-product sequencer.
interface mac_sequencer_if #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned BufferWidth = 2
);
    localparam int unsigned AccWidth = 2 * DataWidth + BufferWidth;

    logic                   Start;
    logic [BufferWidth-1:0] BaseA;
    logic [BufferWidth-1:0] BaseB;
    logic [BufferWidth:0]   Count;
    logic [BufferWidth-1:0] R_Addr1;
    logic [BufferWidth-1:0] R_Addr2;
    logic [DataWidth-1:0]   DataIn1;
    logic [DataWidth-1:0]   DataIn2;
    logic                   Busy;
    logic                   Done;
    logic [AccWidth-1:0]    Result;

    modport master (
        output Start, BaseA, BaseB, Count, DataIn1, DataIn2,
        input  R_Addr1, R_Addr2, Busy, Done, Result
    );

    modport slave (
        input  Start, BaseA, BaseB, Count, DataIn1, DataIn2,
        output R_Addr1, R_Addr2, Busy, Done, Result
    );
endinterface

// File: rtl/mac_sequencer.sv
// Dot-product engine: walks two vectors through the buffer read ports, multiplies
// each pair and accumulates, presenting the sum on Result with a one-cycle Done.
module mac_sequencer #(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned BufferSize  = 4,
    parameter int unsigned BufferWidth = 2
) (
    input logic            clk,
    input logic            rst,
    mac_sequencer_if.slave bus
);
    localparam int unsigned ProdWidth = 2 * DataWidth;
    localparam int unsigned AccWidth  = 2 * DataWidth + BufferWidth;
    localparam int unsigned CntWidth  = BufferWidth + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CntWidth-1:0]    cnt;
    logic [CntWidth-1:0]    idx;
    logic [BufferWidth-1:0] addr1;
    logic [BufferWidth-1:0] addr2;
    logic [ProdWidth-1:0]   prod;
    logic                   prod_valid;
    logic [AccWidth-1:0]    acc;
    logic [AccWidth-1:0]    result;
    logic                   busy;
    logic                   done;
    logic [AccWidth-1:0]    sum_c;

    assign sum_c = acc + AccWidth'(prod);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = (bus.Count == '0) ? DONE : RUN;
            RUN:     if (idx == cnt - CntWidth'(1)) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; addresses are pre-computed for the next RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            addr1      <= '0;
            addr2      <= '0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_next == RUN) || (state_next == DRAIN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        cnt        <= bus.Count;
                        idx        <= '0;
                        acc        <= '0;
                        prod_valid <= 1'b0;
                        if (bus.Count != '0) begin
                            addr1 <= bus.BaseA;
                            addr2 <= bus.BaseB;
                        end else begin
                            result <= '0;
                        end
                    end
                end
                RUN: begin
                    prod       <= ProdWidth'(bus.DataIn1) * ProdWidth'(bus.DataIn2);
                    prod_valid <= 1'b1;
                    idx        <= idx + CntWidth'(1);
                    if (prod_valid) acc <= sum_c;
                    if (state_next == RUN) begin
                        addr1 <= BufferWidth'((32'(addr1) + 32'd1) % BufferSize);
                        addr2 <= BufferWidth'((32'(addr2) + 32'd1) % BufferSize);
                    end else begin
                        addr1 <= '0;
                        addr2 <= '0;
                    end
                end
                DRAIN: begin
                    acc        <= sum_c;
                    result     <= sum_c;
                    prod_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.R_Addr1 = addr1;
    assign bus.R_Addr2 = addr2;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Result  = result;
endmodule
